// File: rtl/fifo_width_conv.sv
`default_nettype none
// ============================================================================
// Module      : fifo_width_conv
// Description : Single-clock FIFO that packs RATIO narrow write lanes into
//               one wide read word. Only complete words are visible to the
//               read side. Sticky overflow/underflow flags and water levels.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_width_conv #(
  parameter int WR_DATA_WIDTH    = 8,
  parameter int RATIO            = 4,
  parameter int RD_DEPTH_WIDTH   = 9,
  parameter int ALMOST_FULL_NUM  = 1950,
  parameter int ALMOST_EMPTY_NUM = 15,
  localparam int RD_DATA_WIDTH   = WR_DATA_WIDTH * RATIO,
  localparam int LW              = $clog2(RATIO),
  localparam int WLW             = RD_DEPTH_WIDTH + LW + 1,
  localparam int RLW             = RD_DEPTH_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  output logic                     wr_full,
  output logic                     almost_full,
  output logic [WLW-1:0]           wr_water_level,
  input  logic                     rd_en,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  output logic                     rd_empty,
  output logic                     almost_empty,
  output logic [RLW-1:0]           rd_water_level,
  output logic                     overflow,
  output logic                     underflow
);

  // Lane counter needs at least one bit even when RATIO = 1 (it then stays 0).
  localparam int          C_LCW   = (LW > 0) ? LW : 1;
  localparam int          C_DEPTH = 1 << RD_DEPTH_WIDTH;
  localparam logic [31:0] C_AF    = ALMOST_FULL_NUM;
  localparam logic [31:0] C_AE    = ALMOST_EMPTY_NUM;

  logic [RD_DATA_WIDTH-1:0]  r_mem [C_DEPTH];
  logic [RD_DATA_WIDTH-1:0]  r_pack;
  logic [RD_DATA_WIDTH-1:0]  r_rd_data;
  logic [RD_DEPTH_WIDTH-1:0] r_wptr;
  logic [RD_DEPTH_WIDTH-1:0] r_rptr;
  logic [RLW-1:0]            r_cnt;
  logic [C_LCW-1:0]          r_lane_cnt;
  logic                      r_ovf;
  logic                      r_udf;

  logic                      w_wr_acc;
  logic                      w_rd_acc;
  logic                      w_last;
  logic                      w_commit;
  logic [RD_DATA_WIDTH-1:0]  w_word;
  logic [WLW-1:0]            w_wr_lvl;

  // Status decoded purely from registered state, so no input reaches an output.
  assign wr_full        = (r_cnt == RLW'(C_DEPTH));
  assign rd_empty       = (r_cnt == '0);
  assign w_wr_lvl       = (WLW'(r_cnt) << LW) + WLW'(r_lane_cnt);
  assign wr_water_level = w_wr_lvl;
  assign rd_water_level = r_cnt;
  assign almost_full    = (32'(w_wr_lvl) >= C_AF);
  assign almost_empty   = (32'(r_cnt) <= C_AE);
  assign overflow       = r_ovf;
  assign underflow      = r_udf;
  assign rd_data        = r_rd_data;

  assign w_wr_acc = wr_en && !wr_full;
  assign w_rd_acc = rd_en && !rd_empty;
  // With RATIO = 1 the lane counter is pinned at 0, so every write is the last lane.
  assign w_last   = (r_lane_cnt == C_LCW'(RATIO - 1));
  assign w_commit = w_wr_acc && w_last;

  // Merge the incoming lane into the partially packed word (lane 0 in LSBs).
  always_comb begin
    w_word = r_pack;
    w_word[r_lane_cnt*WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
  end

  // Data path: packing register and storage array, neither needs reset.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_wr_acc) begin
      r_pack <= w_word;
    end
    if (rst_n && !flush && w_commit) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // Control path: pointers, counts, sticky flags and the read data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_lane_cnt <= '0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_rd_data  <= '0;
    end else if (flush) begin
      // rd_data is intentionally kept across a flush.
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_lane_cnt <= '0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_lane_cnt <= w_last ? '0 : r_lane_cnt + C_LCW'(1);
      end
      if (w_commit) begin
        r_wptr <= r_wptr + RD_DEPTH_WIDTH'(1);
      end
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rptr];
        r_rptr    <= r_rptr + RD_DEPTH_WIDTH'(1);
      end
      case ({w_commit, w_rd_acc})
        2'b10:   r_cnt <= r_cnt + RLW'(1);
        2'b01:   r_cnt <= r_cnt - RLW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (wr_en && wr_full) begin
        r_ovf <= 1'b1;
      end
      if (rd_en && rd_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_width_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_width_conv
// Description : Self-checking bench for fifo_width_conv (default parameters).
//               Reference model tracks words/lanes; read words are checked
//               by a monitor against a queue of expected words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_width_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_full;
  logic        almost_full;
  logic [11:0] wr_water_level;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic        almost_empty;
  logic [9:0]  rd_water_level;
  logic        overflow;
  logic        underflow;

  int          n_checks = 0;
  int          n_fail   = 0;

  int          m_cnt  = 0;
  int          m_lane = 0;
  logic [31:0] m_pack = '0;
  logic [31:0] exp_q[$];
  bit          pend = 1'b0;

  fifo_width_conv dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_full        (wr_full),
    .almost_full    (almost_full),
    .wr_water_level (wr_water_level),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .almost_empty   (almost_empty),
    .rd_water_level (rd_water_level),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus, applied just after a falling edge; model follows.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
    bit wacc;
    bit racc;
    bit commit;
    wacc   = we && (m_cnt < 512);
    racc   = re && (m_cnt > 0);
    commit = 1'b0;
    wr_en  = we;
    wr_data = wd;
    rd_en  = re;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (wacc) begin
      m_pack[m_lane*8 +: 8] = wd;
      m_lane++;
      if (m_lane == 4) begin
        exp_q.push_back(m_pack);
        m_lane = 0;
        commit = 1'b1;
      end
    end
    m_cnt = m_cnt + (commit ? 1 : 0) - (racc ? 1 : 0);
  endtask

  task automatic model_clear();
    m_cnt  = 0;
    m_lane = 0;
    exp_q.delete();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic chk_lvls(input string tag);
    chk({tag, "_wr_lvl"}, 64'(wr_water_level), 64'(m_cnt * 4 + m_lane));
    chk({tag, "_rd_lvl"}, 64'(rd_water_level), 64'(m_cnt));
    chk({tag, "_empty"},  64'(rd_empty), 64'(m_cnt == 0));
    chk({tag, "_full"},   64'(wr_full),  64'(m_cnt == 512));
  endtask

  // Monitor: note an accepted read at the rising edge, compare the word after it.
  always @(posedge clk) pend = rst_n && !flush && rd_en && !rd_empty;

  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_data: got %0h expected no read (queue empty)", rd_data);
      end else begin
        chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Reset state
    chk("rst_empty",   64'(rd_empty), 64'd1);
    chk("rst_full",    64'(wr_full), 64'd0);
    chk("rst_aempty",  64'(almost_empty), 64'd1);
    chk("rst_afull",   64'(almost_full), 64'd0);
    chk("rst_wr_lvl",  64'(wr_water_level), 64'd0);
    chk("rst_rd_lvl",  64'(rd_water_level), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_ovf",     64'(overflow), 64'd0);
    chk("rst_udf",     64'(underflow), 64'd0);

    // Four lanes make one word
    cycle(1, 8'h11, 0);
    cycle(1, 8'h22, 0);
    cycle(1, 8'h33, 0);
    chk("pack3_empty", 64'(rd_empty), 64'd1);
    cycle(1, 8'h44, 0);
    chk("pack4_empty", 64'(rd_empty), 64'd0);
    chk("pack4_rd_lvl", 64'(rd_water_level), 64'd1);
    cycle(0, 8'h00, 1);
    chk("word0", 64'(rd_data), 64'h44332211);
    chk_lvls("after_rd");

    // Partial word stays invisible
    cycle(1, 8'hA1, 0);
    cycle(1, 8'hA2, 0);
    cycle(1, 8'hA3, 0);
    chk("part_empty",  64'(rd_empty), 64'd1);
    chk("part_wr_lvl", 64'(wr_water_level), 64'd3);
    chk("part_rd_lvl", 64'(rd_water_level), 64'd0);
    do_flush();
    chk_lvls("flush1");

    // Fill to capacity
    for (int k = 0; k < 2048; k++) begin
      cycle(1, k[7:0], 0);
      if (k + 1 == 1949) chk("afull_1949", 64'(almost_full), 64'd0);
      if (k + 1 == 1950) chk("afull_1950", 64'(almost_full), 64'd1);
    end
    chk("full_flag",   64'(wr_full), 64'd1);
    chk("full_wr_lvl", 64'(wr_water_level), 64'd2048);
    chk("full_rd_lvl", 64'(rd_water_level), 64'd512);
    chk("full_aempty", 64'(almost_empty), 64'd0);
    cycle(1, 8'hEE, 0);
    chk("ovf_set",    64'(overflow), 64'd1);
    chk("ovf_wr_lvl", 64'(wr_water_level), 64'd2048);

    // Read and write together while full: read wins, write refused
    cycle(1, 8'hDD, 1);
    chk("rw_full_rd_lvl", 64'(rd_water_level), 64'd511);
    chk("rw_full_full",   64'(wr_full), 64'd0);
    chk("rw_full_wr_lvl", 64'(wr_water_level), 64'd2044);

    // Drain the rest; monitor verifies every word
    for (int k = 0; k < 511; k++) begin
      cycle(0, 8'h00, 1);
      if (m_cnt == 16) chk("aempty_16", 64'(almost_empty), 64'd0);
      if (m_cnt == 15) chk("aempty_15", 64'(almost_empty), 64'd1);
    end
    chk_lvls("drained");
    chk("last_word", 64'(rd_data), 64'hFFFEFDFC);

    // Underflow is sticky, rd_data holds, flush clears flags but keeps data
    cycle(0, 8'h00, 1);
    chk("udf_set",     64'(underflow), 64'd1);
    chk("udf_rd_data", 64'(rd_data), 64'hFFFEFDFC);
    cycle(0, 8'h00, 0);
    chk("udf_sticky",  64'(underflow), 64'd1);
    do_flush();
    chk("flush_udf",     64'(underflow), 64'd0);
    chk("flush_ovf",     64'(overflow), 64'd0);
    chk("flush_rd_data", 64'(rd_data), 64'hFFFEFDFC);

    // Reset mid-packing discards the partial word and clears rd_data
    for (int k = 0; k < 6; k++) cycle(1, 8'(k + 1), 0);
    chk("pre_rst_wr_lvl", 64'(wr_water_level), 64'd6);
    do_reset();
    chk("mid_rst_wr_lvl",  64'(wr_water_level), 64'd0);
    chk("mid_rst_rd_lvl",  64'(rd_water_level), 64'd0);
    chk("mid_rst_empty",   64'(rd_empty), 64'd1);
    chk("mid_rst_rd_data", 64'(rd_data), 64'd0);

    // Commit and read in the same cycle at cnt = 0: no bypass
    cycle(1, 8'h55, 0);
    cycle(1, 8'h56, 0);
    cycle(1, 8'h57, 0);
    cycle(1, 8'h58, 1);
    chk("nobypass_udf",    64'(underflow), 64'd1);
    chk("nobypass_rd_lvl", 64'(rd_water_level), 64'd1);
    chk("nobypass_rd_data", 64'(rd_data), 64'd0);
    cycle(0, 8'h00, 1);
    chk("nobypass_word", 64'(rd_data), 64'h58575655);
    cycle(0, 8'h00, 0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
